iter_muldiv: RTL and testbench
==============================

ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled when idle.
REQ-005 The block SHALL have port op, input, 2 bits: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: a is the multiplicand or dividend; b is the multiplier or divisor.
REQ-007 The block SHALL have ports hi_we and lo_we, input, 1 bit each, and wdata, input, WIDTH bits: mthi/mtlo write path.
REQ-008 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse; hi/lo hold the new result.
REQ-010 The block SHALL have ports hi and lo, output, WIDTH bits each: HI and LO register contents, driven directly from registers.

Function
REQ-011 The block SHALL implement states IDLE, RUN and FIN; busy SHALL be 1 exactly when the state is not IDLE.
REQ-012 In IDLE with start=1, the edge SHALL latch op, the sign flags, |a| and |b| (unsigned ops take a and b as-is), clear an iteration counter, and enter RUN.
REQ-013 RUN SHALL perform one radix-2 step per edge (shift-add multiply, restoring divide) and enter FIN on the WIDTH-th step.
REQ-014 The FIN edge SHALL apply sign correction, write hi/lo, set done=1 for exactly one cycle and return to IDLE.
REQ-015 Latency: with start sampled at edge E0, hi/lo SHALL update and done SHALL be 1 after edge E(WIDTH+1), 33 edges for WIDTH=32.
REQ-016 mult/multu SHALL give {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per op.
REQ-017 div/divu SHALL give lo = quotient truncated toward zero and hi = remainder, with the remainder taking the sign of the dividend.
REQ-018 Signed MIN / -1 SHALL give lo = MIN and hi = 0 without special-casing.
REQ-019 Divide-by-zero (b=0, div or divu) SHALL give lo = all ones and hi = original a, with no sign correction and full latency.
REQ-020 start asserted while busy=1 SHALL be ignored; latched operands and op SHALL remain unchanged.
REQ-021 hi_we/lo_we in IDLE SHALL write wdata to hi/lo on that edge; while busy=1 they SHALL be ignored.
REQ-022 If start and hi_we/lo_we coincide in IDLE, the write SHALL take effect and the later FIN result SHALL overwrite it.
REQ-023 a, b and op SHALL be "don't care" after the accepting edge; the result SHALL depend only on the latched values.
REQ-024 done SHALL be registered, and SHALL never be 1 when busy=1.

Reset
REQ-025 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter and operand registers.
REQ-026 Reset mid-RUN or in FIN SHALL abandon the operation with no hi/lo write; the first start after reset release SHALL behave per REQ-015.
REQ-027 While reset=1, start, hi_we and lo_we SHALL have no effect.

Verification
REQ-028 The bench SHALL check (WIDTH=32) multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 edges after the start edge, busy high for 33 cycles.
REQ-029 The bench SHALL check mult a=0xFFFFFFFD b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-030 The bench SHALL check div a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu a=7 b=2 -> lo=3, hi=1.
REQ-031 The bench SHALL check div a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678; and div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 The bench SHALL check multu 3*5 with a new start (divu 9/2) and hi_we wdata=0xDEADBEEF pulsed at RUN step 5 -> both ignored; result hi=0, lo=15.
REQ-033 The bench SHALL check hi_we wdata=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5; then reset pulsed at RUN step 10 of a multu -> busy=0, done=0, hi=lo=0 asynchronously, and the next multu 2*3 -> lo=6 after 33 edges.

Source files
------------

// File: rtl/iter_muldiv_if.sv
// rtl/iter_muldiv_if.sv - request/result bundle for the iterative multiply/divide unit
// Purpose: groups the operation request, HI/LO write path and result signals.
// Ports (master drives / slave drives):
//   master -> slave : start, op[1:0], a, b, hi_we, lo_we, wdata
//   slave -> master : busy, done, hi, lo
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - radix-2 iterative mult/multu/div/divu with HI/LO registers
// Purpose: one-bit-per-cycle shift-add multiply and restoring divide on operand
//   magnitudes, with sign correction applied once on the final cycle.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - iter_muldiv_if.slave: start/op/a/b request, hi_we/lo_we/wdata
//           direct HI/LO writes, busy/done status, hi/lo result registers
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  iter_muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic             op_div;
  logic             sign_a;
  logic             sign_b;
  logic             b_zero;
  logic [WIDTH-1:0] opd;    // multiplicand (mult) or divisor (div) magnitude
  logic [WIDTH-1:0] p_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] p_lo;   // multiplier bits shifting out / quotient shifting in
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             done_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic             res_neg;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;

  always_comb begin
    a_neg     = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg     = ~bus.op[0] & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;

    // Multiply step: add multiplicand when the current multiplier bit is set,
    // then shift the {carry, p_hi, p_lo} chain right by one.
    mul_add   = p_lo[0] ? opd : '0;
    mul_sum   = {1'b0, p_hi} + {1'b0, mul_add};

    // Restoring divide step: shift in the next dividend bit, subtract if it fits.
    div_shift = {p_hi, p_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opd};
    div_diff  = div_shift[WIDTH-1:0] - opd;

    // Sign flags are only ever set for signed ops, so unsigned ops pass through.
    // With a zero divisor p_hi ends up holding |a|; negating it back by the
    // dividend sign restores the original a, and the all-ones quotient is kept.
    res_neg   = sign_a ^ sign_b;
    prod_res  = res_neg ? -{p_hi, p_lo} : {p_hi, p_lo};
    quo_res   = b_zero ? '1 : (res_neg ? -p_lo : p_lo);
    rem_res   = sign_a ? -p_hi : p_hi;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      opd    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_r <= bus.wdata;
          if (bus.lo_we) lo_r <= bus.wdata;
          if (bus.start) begin
            op_div <= bus.op[1];
            sign_a <= a_neg;
            sign_b <= b_neg;
            b_zero <= (bus.b == '0);
            opd    <= bus.op[1] ? b_mag : a_mag;
            p_lo   <= bus.op[1] ? a_mag : b_mag;
            p_hi   <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (op_div) begin
            p_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            p_lo <= {p_lo[WIDTH-2:0], div_ge};
          end else begin
            p_hi <= mul_sum[WIDTH:1];
            p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= FIN;
        end
        FIN: begin
          if (op_div) begin
            hi_r <= rem_res;
            lo_r <= quo_res;
          end else begin
            {hi_r, lo_r} <= prod_res;
          end
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_iter_muldiv.sv
// tb/tb_iter_muldiv.sv - self-checking bench for iter_muldiv against an arithmetic model
module tb_iter_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  iter_muldiv_if #(.WIDTH(W)) bus ();
  iter_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: return sa * sb;
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called #1 after a rising edge with the unit idle. inj_step >= 0 pulses a
  // conflicting start plus HI/LO writes right after that RUN step.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_step, input bit coinc_we,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int lat, output int busy_n);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (coinc_we) begin
      bus.hi_we = 1'b1;
      bus.wdata = 32'h0BADF00D;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    if (coinc_we) check("coinc_hi_write", 64'(bus.hi), 64'h0BADF00D);
    lat    = 0;
    busy_n = bus.busy ? 1 : 0;
    while (!bus.done && lat < 100) begin
      if (lat == inj_step) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd9;
        bus.b     = 32'd2;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEADBEEF;
      end
      @(posedge clk); #1;
      lat++;
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      if (bus.busy) busy_n++;
    end
    hi = bus.hi;
    lo = bus.lo;
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t dir [6];

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] rh;
    logic [31:0] rl;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int lat;
    int bn;

    dir[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    dir[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    dir[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    dir[3] = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    dir[4] = '{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    dir[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    #1;
    // Requests while held in reset must not take effect.
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    reset     = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(dir[i].op, dir[i].a, dir[i].b, -1, 1'b0, rh, rl, lat, bn);
      check($sformatf("dir%0d_hi", i), 64'(rh), 64'(dir[i].eh));
      check($sformatf("dir%0d_lo", i), 64'(rl), 64'(dir[i].el));
      check($sformatf("dir%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("dir%0d_busy_cycles", i), 64'(bn), 64'd33);
      check($sformatf("dir%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      check($sformatf("dir%0d_done_one_cycle", i), 64'(bus.done), 64'd0);
    end

    // Conflicting start and HI/LO writes during RUN are ignored.
    run_op(2'b01, 32'd3, 32'd5, 5, 1'b0, rh, rl, lat, bn);
    check("busy_ign_hi", 64'(rh), 64'd0);
    check("busy_ign_lo", 64'(rl), 64'd15);
    check("busy_ign_latency", 64'(lat), 64'd33);
    @(posedge clk); #1;
    check("busy_ign_no_restart", 64'(bus.busy), 64'd0);

    // Write coinciding with start is visible, then overwritten by the result.
    run_op(2'b10, 32'd100, 32'hFFFFFFF9, -1, 1'b1, rh, rl, lat, bn);
    check("coinc_result", {rh, rl}, model(2'b10, 32'd100, 32'hFFFFFFF9));

    // Direct HI/LO writes in IDLE.
    bus.hi_we = 1'b1;
    bus.wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    check("mthi", 64'(bus.hi), 64'hA5A5A5A5);
    check("mtlo", 64'(bus.lo), 64'h5A5A5A5A);

    // Asynchronous reset in the middle of RUN.
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = $urandom;
    bus.b     = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("mid_run_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    check("async_rst_hi", 64'(bus.hi), 64'd0);
    check("async_rst_lo", 64'(bus.lo), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(2'b01, 32'd2, 32'd3, -1, 1'b0, rh, rl, lat, bn);
    check("after_rst_lo", 64'(rl), 64'd6);
    check("after_rst_hi", 64'(rh), 64'd0);
    check("after_rst_latency", 64'(lat), 64'd33);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick(int'($urandom_range(0, 7)));
      rb  = pick(int'($urandom_range(0, 7)));
      run_op(rop, ra, rb, -1, 1'b0, rh, rl, lat, bn);
      check($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), {rh, rl}, model(rop, ra, rb));
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'd33);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
